// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter:
// FSM state encoding, owner identifiers and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // Where a transaction goes once memory has accepted it: writes are done,
  // reads still owe a data beat.
  function automatic arb_state_e issue_done_state(input logic rw);
    arb_state_e nxt;
    if (rw) begin
      nxt = IDLE;
    end else begin
      nxt = WAIT_RESP;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select between the icache and dcache request paths.
// Build option MEM_ARB_RR_EN: when defined, ties alternate based on the
// last granted owner; when undefined, the dcache always wins ties and the
// pointer input does not exist.
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic last_owner,
`endif
  input  logic ic_valid,
  input  logic dc_valid,
  output logic grant_valid,
  output logic grant_owner
);

  // Combinational grant: a lone requester always wins, ties follow the policy.
  always_comb begin
    grant_valid = ic_valid | dc_valid;
    grant_owner = OWN_DC;
`ifdef MEM_ARB_RR_EN
    if (ic_valid && dc_valid) begin
      grant_owner = ~last_owner;
    end else if (ic_valid) begin
      grant_owner = OWN_IC;
    end else begin
      grant_owner = OWN_DC;
    end
`else
    if (dc_valid) begin
      grant_owner = OWN_DC;
    end else if (ic_valid) begin
      grant_owner = OWN_IC;
    end else begin
      grant_owner = OWN_DC;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single main-memory port shared by the
// icache refill path and the dcache refill/writeback path. One transaction
// is in flight at a time; read data is routed back to the owning cache.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking (default:
// fixed dcache priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_req_ready,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  input  logic                dc_req_valid,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [DATA_W-1:0]   dc_req_data,
  input  logic [DATA_W/8-1:0] dc_req_mask,
  output logic                dc_req_ready,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic                mem_req_valid,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_data,
  output logic [DATA_W/8-1:0] mem_req_mask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;

  logic grant_valid;
  logic grant_owner;
  logic capture;
  logic ic_ready_raw, dc_ready_raw;
  logic ic_rvalid_raw, dc_rvalid_raw;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
`endif

  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_owner  (last_q),
`endif
    .ic_valid    (ic_req_valid),
    .dc_valid    (dc_req_valid),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Next-state logic plus the combinational ready and response strobes.
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    ic_ready_raw  = 1'b0;
    dc_ready_raw  = 1'b0;
    ic_rvalid_raw = 1'b0;
    dc_rvalid_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          capture = 1'b1;
          state_d = ISSUE;
          if (grant_owner == OWN_DC) begin
            dc_ready_raw = 1'b1;
          end else begin
            ic_ready_raw = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (valid_q && mem_req_ready) begin
          state_d = issue_done_state(rw_q);
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_DC) begin
            dc_rvalid_raw = 1'b1;
          end else begin
            ic_rvalid_raw = 1'b1;
          end
        end else begin
          state_d = WAIT_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the granted request and drop mem_req_valid on the memory handshake.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    owner_d = owner_q;
    if (capture) begin
      valid_d = 1'b1;
      owner_d = grant_owner;
      if (grant_owner == OWN_DC) begin
        rw_d   = dc_req_rw;
        addr_d = dc_req_addr;
        data_d = dc_req_data;
        mask_d = dc_req_mask;
      end else begin
        rw_d   = 1'b0;
        addr_d = ic_req_addr;
        data_d = {DATA_W{1'b0}};
        mask_d = {MASK_W{1'b0}};
      end
    end else if ((state_q == ISSUE) && mem_req_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State, memory-request and busy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      mask_q  <= {MASK_W{1'b0}};
      owner_q <= OWN_IC;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who won the last grant; only a grant moves the pointer.
  always_comb begin
    if (capture) begin
      last_d = grant_owner;
    end else begin
      last_d = last_q;
    end
  end

  // Round-robin pointer register; resetting to icache gives the dcache the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= OWN_IC;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Ready/response strobes are forced low while reset is asserted so that a
  // response landing during reset never reaches a cache.
  assign ic_req_ready  = ic_ready_raw  & reset;
  assign dc_req_ready  = dc_ready_raw  & reset;
  assign ic_resp_valid = ic_rvalid_raw & reset;
  assign dc_resp_valid = dc_rvalid_raw & reset;
  assign ic_resp_data  = ic_resp_valid ? mem_resp_data : {DATA_W{1'b0}};
  assign dc_resp_data  = dc_resp_valid ? mem_resp_data : {DATA_W{1'b0}};

  assign mem_req_valid = valid_q;
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign mem_req_mask  = mask_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed cache traffic, a
// behavioural memory, a transaction-level reference model that predicts
// grants and responses, and a monitor that pops expectations.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;
  localparam int M_FREE    = 0;
  localparam int M_TO_MEM  = 1;
  localparam int M_TO_DATA = 2;

  typedef struct packed {
    logic          owner;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } txn_t;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data, dc_resp_data;
  logic [MW-1:0] dc_req_mask;
  logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_resp_data;
  logic [MW-1:0] mem_req_mask;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_rw      (dc_req_rw),
    .dc_req_addr    (dc_req_addr),
    .dc_req_data    (dc_req_data),
    .dc_req_mask    (dc_req_mask),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy)
  );

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus queues and knobs
  txn_t ic_q[$];
  txn_t dc_q[$];
  int   go_pct    = 100;
  int   rdy_pct   = 100;
  int   lat_min   = 0;
  int   lat_max   = 0;
  int   spur_pct  = 0;
  int   stall_cnt = 0;
  bit   fix_data  = 1'b0;
  bit   force_resp = 1'b0;
  bit   rd_pending = 1'b0;
  int   lat_cnt   = 0;
  bit   ic_acc    = 1'b0;
  bit   dc_acc    = 1'b0;

  // Reference model state
  int    m_phase = M_FREE;
  logic  m_last  = IC;
  txn_t  m_cur;
  bit    rst_prev = 1'b0;
  txn_t  exp_mem_q[$];
  resp_t exp_resp_q[$];
  bit    rec_grants = 1'b0;
  logic  grants[$];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (ic_q.size() == 0 && dc_q.size() == 0 && !ic_req_valid && !dc_req_valid &&
          m_phase == M_FREE && !rd_pending) break;
      cyc(1);
    end
    chk("drain_in_time", (i < bound), 1'b1);
    cyc(2);
  endtask

  function automatic txn_t rand_dc();
    txn_t t;
    t.owner = DC;
    t.rw    = 1'($urandom_range(1));
    t.addr  = $urandom & 32'hFFFF_FFF0;
    t.data  = {$urandom, $urandom, $urandom, $urandom};
    t.mask  = 16'($urandom);
    return t;
  endfunction

  function automatic txn_t mk_ic(input logic [AW-1:0] a);
    txn_t t;
    t = '0;
    t.owner = IC;
    t.addr  = a;
    return t;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Requester and memory drivers, one step after each rising edge.
  initial begin
    txn_t t;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_data = '0; dc_req_mask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!ic_req_valid || ic_acc) begin
        if (ic_q.size() > 0 && int'($urandom_range(99)) < go_pct) begin
          t = ic_q.pop_front();
          ic_req_valid = 1'b1; ic_req_addr = t.addr;
        end else begin
          ic_req_valid = 1'b0; ic_req_addr = $urandom;
        end
      end
      if (!dc_req_valid || dc_acc) begin
        if (dc_q.size() > 0 && int'($urandom_range(99)) < go_pct) begin
          t = dc_q.pop_front();
          dc_req_valid = 1'b1; dc_req_rw = t.rw; dc_req_addr = t.addr;
          dc_req_data = t.data; dc_req_mask = t.mask;
        end else begin
          dc_req_valid = 1'b0; dc_req_rw = 1'($urandom); dc_req_addr = $urandom;
          dc_req_data = {$urandom, $urandom, $urandom, $urandom}; dc_req_mask = 16'($urandom);
        end
      end
      if (stall_cnt > 0) begin
        mem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_req_ready = (int'($urandom_range(99)) < rdy_pct);
      end
      mem_resp_data = fix_data ? {4{32'hDEAD_BEEF}} : {$urandom, $urandom, $urandom, $urandom};
      if (force_resp) begin
        mem_resp_valid = 1'b1; force_resp = 1'b0; rd_pending = 1'b0;
      end else if (rd_pending) begin
        if (lat_cnt == 0) begin
          mem_resp_valid = 1'b1;
        end else begin
          mem_resp_valid = 1'b0; lat_cnt--;
        end
      end else begin
        mem_resp_valid = (int'($urandom_range(99)) < spur_pct);
      end
    end
  end

  // Reference model: predicts grants and request phases, pushes expectations.
  initial begin
    logic w, any;
    txn_t t;
    forever begin
      @(negedge clk);
      ic_acc = ic_req_valid && ic_req_ready;
      dc_acc = dc_req_valid && dc_req_ready;
      if (reset) begin
        if (mem_resp_valid && rd_pending) begin
          rd_pending = 1'b0;
        end else if (mem_req_valid && mem_req_ready && !mem_req_rw) begin
          rd_pending = 1'b1;
          lat_cnt = $urandom_range(lat_max, lat_min);
        end
      end
      if (!reset) begin
        chk("rst_ic_req_ready", ic_req_ready, 1'b0);
        chk("rst_dc_req_ready", dc_req_ready, 1'b0);
        chk("rst_resp_valids", {ic_resp_valid, dc_resp_valid}, 2'b00);
        if (rst_prev) begin
          chk("rst_mem_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask, busy}, '0);
        end
        m_phase = M_FREE;
        m_last  = IC;
        exp_mem_q.delete();
        exp_resp_q.delete();
      end else begin
        case (m_phase)
          M_FREE: begin
            any = ic_req_valid || dc_req_valid;
            if (ic_req_valid && dc_req_valid) begin
`ifdef MEM_ARB_RR_EN
              w = ~m_last;
`else
              w = DC;
`endif
            end else begin
              w = dc_req_valid ? DC : IC;
            end
            chk("ic_req_ready", ic_req_ready, any && (w == IC));
            chk("dc_req_ready", dc_req_ready, any && (w == DC));
            chk("idle_mem_valid_busy", {mem_req_valid, busy}, 2'b00);
            if (any) begin
              if (w == DC) begin
                t.owner = DC; t.rw = dc_req_rw; t.addr = dc_req_addr;
                t.data = dc_req_data; t.mask = dc_req_mask;
              end else begin
                t = mk_ic(ic_req_addr);
              end
              exp_mem_q.push_back(t);
              m_cur = t;
              m_last = w;
              m_phase = M_TO_MEM;
              if (rec_grants) grants.push_back(dc_req_ready ? DC : IC);
            end
          end
          M_TO_MEM: begin
            chk("issue_readys", {ic_req_ready, dc_req_ready}, 2'b00);
            chk("issue_valid_busy", {mem_req_valid, busy}, 2'b11);
            chk("issue_payload",
                {mem_req_rw, mem_req_addr, mem_req_mask, (mem_req_rw ? mem_req_data : {DW{1'b0}})},
                {m_cur.rw, m_cur.addr, m_cur.mask, (m_cur.rw ? m_cur.data : {DW{1'b0}})});
            if (mem_req_ready) m_phase = m_cur.rw ? M_FREE : M_TO_DATA;
          end
          default: begin
            chk("wait_readys", {ic_req_ready, dc_req_ready}, 2'b00);
            chk("wait_valid_busy", {mem_req_valid, busy}, 2'b01);
            if (mem_resp_valid) begin
              exp_resp_q.push_back({m_cur.owner, mem_resp_data});
              m_phase = M_FREE;
            end
          end
        endcase
      end
      rst_prev = !reset;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake or response.
  initial begin
    txn_t  e;
    resp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_mem_q.size() == 0) begin
            chk("mem_req_unexpected", mem_req_valid, 1'b0);
          end else begin
            e = exp_mem_q.pop_front();
            chk("mem_req_rw", mem_req_rw, e.rw);
            chk("mem_req_addr", mem_req_addr, e.addr);
            chk("mem_req_mask", mem_req_mask, e.mask);
            if (e.rw) chk("mem_req_data", mem_req_data, e.data);
          end
        end
        if (ic_resp_valid || dc_resp_valid) begin
          if (exp_resp_q.size() == 0) begin
            chk("resp_unexpected", {ic_resp_valid, dc_resp_valid}, 2'b00);
          end else begin
            r = exp_resp_q.pop_front();
            chk("resp_owner", {ic_resp_valid, dc_resp_valid}, (r.owner == DC) ? 2'b01 : 2'b10);
            chk("resp_data", (r.owner == DC) ? dc_resp_data : ic_resp_data, r.data);
          end
        end else if (exp_resp_q.size() > 0) begin
          r = exp_resp_q.pop_front();
          chk("resp_missing", {ic_resp_valid, dc_resp_valid}, (r.owner == DC) ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // Test sequence
  initial begin
    txn_t t;
    logic exp_g;
    int i;
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // Lone icache read at 0x40, response one cycle after entering WAIT_RESP.
    lat_min = 1; lat_max = 1; fix_data = 1'b1;
    ic_q.push_back(mk_ic(32'h0000_0040));
    wait_idle(100);
    fix_data = 1'b0; lat_min = 0; lat_max = 0;

    // Simultaneous icache read and dcache write: dcache first.
    t = rand_dc(); t.rw = 1'b1; t.addr = 32'h0000_0200; t.mask = 16'hFFFF;
    ic_q.push_back(mk_ic(32'h0000_0100));
    dc_q.push_back(t);
    wait_idle(100);

    // Memory stalls the request in ISSUE while the other cache waits.
    stall_cnt = 8;
    t = rand_dc(); t.rw = 1'b0; t.addr = 32'h0000_0300;
    dc_q.push_back(t);
    ic_q.push_back(mk_ic(32'h0000_0340));
    wait_idle(200);

    // Both requesters continuously valid: grant order.
    rec_grants = 1'b1;
    for (i = 0; i < 4; i++) begin
      t = rand_dc(); t.rw = 1'b1;
      dc_q.push_back(t);
      ic_q.push_back(mk_ic(32'h0000_1000 + 32'(i * 16)));
    end
    wait_idle(200);
    rec_grants = 1'b0;
    chk("grant_count", 32'(grants.size()), 32'd8);
    for (i = 0; i < 8 && i < grants.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? DC : IC;
`else
      exp_g = (i < 4) ? DC : IC;
`endif
      chk($sformatf("grant_order_%0d", i), grants[i], exp_g);
    end

    // Spurious memory responses while idle and during a stalled ISSUE.
    spur_pct = 100;
    cyc(10);
    stall_cnt = 6;
    t = rand_dc(); t.rw = 1'b0;
    dc_q.push_back(t);
    wait_idle(100);
    spur_pct = 0;
    cyc(2);

    // Reset held for two cycles in WAIT_RESP, then a late response pulse.
    lat_min = 40; lat_max = 40;
    ic_q.push_back(mk_ic(32'h0000_0500));
    for (i = 0; i < 50 && m_phase != M_TO_DATA; i++) cyc(1);
    chk("reached_wait_resp", (m_phase == M_TO_DATA), 1'b1);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    force_resp = 1'b1;
    cyc(6);
    lat_min = 0; lat_max = 0;

    // Randomized traffic in batches with varying memory behaviour.
    for (int b = 0; b < 6; b++) begin
      go_pct   = $urandom_range(100, 30);
      rdy_pct  = $urandom_range(100, 20);
      lat_max  = $urandom_range(4, 0);
      spur_pct = $urandom_range(30, 0);
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(1) == 0) begin
          ic_q.push_back(mk_ic($urandom & 32'hFFFF_FFF0));
        end else begin
          dc_q.push_back(rand_dc());
        end
      end
      wait_idle(5000);
    end
    spur_pct = 0;
    cyc(3);

    chk("mem_expect_drained", 32'(exp_mem_q.size()), 32'd0);
    chk("resp_expect_drained", 32'(exp_resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
